toggle_bank_arbiter: RTL and testbench
======================================

Name: toggle_bank_arbiter

Overview:
- Shares one bank of T flip-flops (WIDTH bits) between NREQ requesters.
- Each requester asks to toggle a set of bank bits, given as a mask. The block picks one requester round-robin, gives it a one-cycle grant, then applies q <= q ^ mask.
- Sits between requester logic and the toggle register that the rest of the design reads as shared state.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: width of the toggle bank and of each mask.
- CNTW, 16: width of the applied-toggle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; new grants are issued only while high.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- mask  input  NREQ*WIDTH  toggle masks; requester i owns bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant pulse, registered.
- busy  output  1  high while state is not IDLE.
- q  output  WIDTH  toggle bank contents.
- toggle_cnt  output  CNTW  count of applied toggles.

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, busy=0, q=0, toggle_cnt=0, ptr=0, mask_r=0.
- States: IDLE, GRANT, APPLY.
- IDLE -> GRANT at an edge where en=1 and |req.
  - Winner: first set req bit, searching upward from ptr with wrap modulo NREQ.
  - Same edge: gnt[winner]<=1, mask_r<=mask of winner, ptr<=(winner+1) mod NREQ.
- GRANT -> APPLY, unconditionally, at the next edge: gnt<=0, q<=q^mask_r, toggle_cnt<=toggle_cnt+1 (wraps).
- APPLY:
  - -> GRANT if en=1 and |req; same selection rules as IDLE, back-to-back.
  - otherwise -> IDLE.
  - Peak throughput: one grant per 2 cycles.
- Latency: req sampled at edge k -> gnt high during cycle k..k+1 -> q updated at edge k+1.
- Requester handshake:
  - Hold req and mask stable until gnt is seen, then drop req.
  - req still high in APPLY counts as a new request; fairness comes from ptr.
  - mask is sampled only at the grant edge.
  - Dropping req before its grant withdraws the request; no toggle happens.
- en=0 while in GRANT or APPLY: the current transaction completes (toggle applied); no new grant follows.
- mask_r=0: grant still issued, q unchanged, toggle_cnt still increments.
- Overlapping masks from successive winners apply sequentially as XOR; nothing is merged within one cycle.
- gnt is never multi-hot and never high outside GRANT.
- busy = (state != IDLE).
- Reset mid-operation: pending toggle discarded; q returns to 0.

Decomposition:
- Shared include toggle_defs.vh: state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_APPLY=2'd2.
- Sub-module rr_pick (combinational, parameter NREQ):
  - Inputs: req, ptr.
  - Outputs: winner index, valid.
- Top block holds the FSM, ptr, mask_r, q, toggle_cnt.

Test Plan:
- Reset: rst=1 in mid-stream -> q=0x00, gnt=0, busy=0, toggle_cnt=0 immediately, without waiting for a clock edge.
- Single request: en=1, req=4'b0001, mask0=0x0F -> gnt=0001 for exactly one cycle; q=0x0F one edge later; toggle_cnt=1; back to IDLE.
- Round robin: req=1111 held, masks 0x01/0x02/0x04/0x08:
  - grants in order 0,1,2,3,0, one every 2 cycles, back-to-back;
  - q=0x0F after the fourth grant completes, 0x0E after the fifth.
- Enable gating: en=0, req=0010 for 5 cycles -> no gnt, busy=0; raise en -> gnt=0010 at the next edge.
- en falls during GRANT (mask=0x80) -> q^=0x80 still applied; state returns to IDLE; no further grants.
- rst pulsed during APPLY -> q=0, toggle_cnt=0, ptr=0; then req=1010 -> requester 1 granted first.

Source files
------------

// File: rtl/toggle_bank_arbiter_pkg.sv
// Shared types for the toggle bank arbiter: FSM state encoding and helpers.
package toggle_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Index width needed to address n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_bank_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching upward from ptr, wrapping modulo NREQ.
module toggle_bank_arbiter_rr_pick
    import toggle_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PTRW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [PTRW-1:0] winner,
    output logic            valid
);

    logic [PTRW-1:0] cand [NREQ];

    // cand[k] is the requester index k positions above ptr, wrapped into range.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [PTRW:0] sum;
        assign sum = {1'b0, ptr} + (PTRW+1)'(gi);
        assign cand[gi] = (sum >= (PTRW+1)'(NREQ)) ? PTRW'(sum - (PTRW+1)'(NREQ))
                                                   : PTRW'(sum);
    end

    // Scan from the far end so the closest candidate to ptr overwrites last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter sharing one T flip-flop bank between NREQ requesters;
// each grant is followed one edge later by q <= q ^ mask of the winner.
module toggle_bank_arbiter
    import toggle_bank_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [CNTW-1:0]       toggle_cnt
);

    localparam int PTRW = idx_width(NREQ);

    state_t           state_reg, state_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic [PTRW-1:0]  ptr_reg, ptr_next;
    logic [WIDTH-1:0] mask_r_reg, mask_r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [CNTW-1:0]  cnt_reg, cnt_next;

    logic [PTRW-1:0]  pick_winner;
    logic             pick_valid;
    logic [WIDTH-1:0] mask_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign mask_arr[gi] = mask[gi*WIDTH +: WIDTH];
    end

    toggle_bank_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            ptr_reg    <= '0;
            mask_r_reg <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            ptr_reg    <= ptr_next;
            mask_r_reg <= mask_r_next;
            q_reg      <= q_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        gnt_next    = '0;
        ptr_next    = ptr_reg;
        mask_r_next = mask_r_reg;
        q_next      = q_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            ST_IDLE, ST_APPLY: begin
                if (en && pick_valid) begin
                    state_next               = ST_GRANT;
                    gnt_next[pick_winner]    = 1'b1;
                    mask_r_next              = mask_arr[pick_winner];
                    ptr_next                 = (pick_winner == PTRW'(NREQ - 1))
                                               ? '0 : pick_winner + PTRW'(1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // The captured mask is applied regardless of en or req now.
                state_next = ST_APPLY;
                q_next     = q_reg ^ mask_r_reg;
                cnt_next   = cnt_reg + CNTW'(1);
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign gnt        = gnt_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign q          = q_reg;
    assign toggle_cnt = cnt_reg;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Directed bench for toggle_bank_arbiter with a scoreboard of expected grants and bank state.
module tb_toggle_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [CNTW-1:0]       toggle_cnt;

    toggle_bank_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .mask       (mask),
        .gnt        (gnt),
        .busy       (busy),
        .q          (q),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] q;
        logic [CNTW-1:0]  cnt;
    } exp_t;

    exp_t             sb[$];
    exp_t             cur;
    logic [WIDTH-1:0] q_model;
    logic [CNTW-1:0]  cnt_model;
    int               checks   = 0;
    int               failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mask(input int idx, input logic [WIDTH-1:0] m);
        mask[idx*WIDTH +: WIDTH] = m;
    endtask

    task automatic expect_grant(input int idx, input logic [WIDTH-1:0] m);
        exp_t e;
        q_model   = q_model ^ m;
        cnt_model = cnt_model + 16'd1;
        e.gnt = NREQ'(1 << idx);
        e.q   = q_model;
        e.cnt = cnt_model;
        sb.push_back(e);
    endtask

    // Returns at the falling edge where the grant is visible.
    task automatic wait_grant(input string tag, input int max_wait);
        bit found = 1'b0;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_grant_seen"}, 32'(found), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            cur = sb.pop_front();
            chk({tag, "_gnt"}, 32'(gnt), 32'(cur.gnt));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic check_apply(input string tag);
        @(negedge clk);
        chk({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
        chk({tag, "_q"}, 32'(q), 32'(cur.q));
        chk({tag, "_cnt"}, 32'(toggle_cnt), 32'(cur.cnt));
    endtask

    task automatic pulse_reset_sync();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_model   = '0;
        cnt_model = '0;
        sb.delete();
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        mask = '0;
        q_model   = '0;
        cnt_model = '0;

        repeat (2) @(negedge clk);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cnt", 32'(toggle_cnt), 32'd0);
        rst = 1'b0;

        // Single request from requester 0.
        @(negedge clk);
        en = 1'b1;
        req = 4'b0001;
        set_mask(0, 8'h0F);
        expect_grant(0, 8'h0F);
        wait_grant("single", 1);
        req = '0;
        check_apply("single");
        @(negedge clk);
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_gnt", 32'(gnt), 32'd0);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_q", 32'(q), 32'd0);
        chk("async_rst_cnt", 32'(toggle_cnt), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q_model   = '0;
        cnt_model = '0;

        // Round robin with all four requesting, back-to-back grants.
        pulse_reset_sync();
        for (int i = 0; i < NREQ; i++) set_mask(i, 8'(1 << i));
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expect_grant(i % NREQ, 8'(1 << (i % NREQ)));
            wait_grant($sformatf("rr%0d", i), 1);
            if (i == 4) req = '0;
            check_apply($sformatf("rr%0d", i));
        end
        @(negedge clk);
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Enable gating: request held with en low produces nothing.
        en  = 1'b0;
        req = 4'b0010;
        set_mask(1, 8'h02);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("gate%0d_gnt", i), 32'(gnt), 32'd0);
            chk($sformatf("gate%0d_busy", i), 32'(busy), 32'd0);
        end
        en = 1'b1;
        expect_grant(1, 8'h02);
        wait_grant("gate_release", 1);
        req = '0;
        check_apply("gate_release");

        // en falls during GRANT: toggle still lands, nothing further granted.
        @(negedge clk);
        req = 4'b0100;
        set_mask(2, 8'h80);
        expect_grant(2, 8'h80);
        wait_grant("en_fall", 1);
        en = 1'b0;
        check_apply("en_fall");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("en_fall_quiet%0d_gnt", i), 32'(gnt), 32'd0);
            chk($sformatf("en_fall_quiet%0d_busy", i), 32'(busy), 32'd0);
        end
        chk("en_fall_q_hold", 32'(q), 32'(q_model));
        req = '0;

        // Reset during APPLY after a grant to requester 2 (ptr would be 3).
        en = 1'b1;
        req = 4'b0100;
        set_mask(2, 8'h0F);
        expect_grant(2, 8'h0F);
        wait_grant("rst_apply", 1);
        req = '0;
        @(posedge clk);
        #2;
        chk("rst_apply_in_apply_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_apply_q", 32'(q), 32'd0);
        chk("rst_apply_cnt", 32'(toggle_cnt), 32'd0);
        chk("rst_apply_busy", 32'(busy), 32'd0);
        q_model   = '0;
        cnt_model = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        set_mask(1, 8'h02);
        set_mask(3, 8'h08);
        req = 4'b1010;
        expect_grant(1, 8'h02);
        wait_grant("post_rst", 2);
        req = '0;
        check_apply("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
